// File: rtl/mem_if_pkg.sv
// Shared defaults and FSM state encoding for the CPU<->RAM initiator.
package mem_if_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W      = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SETUP  = 2'd1;
  localparam state_t ACCESS = 2'd2;
  localparam state_t DONE   = 2'd3;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter with zero flag; holds at zero instead of wrapping.
module mem_wait_counter
  import mem_if_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// MAR/MDR owner and RAM strobe sequencer with programmable wait states.
// Optional address range fault enabled by `define MEM_RANGE_CHECK_EN.
module mem_access_ctrl
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned WAIT_CYCLES = 2
`ifdef MEM_RANGE_CHECK_EN
  ,
  parameter int unsigned MEM_WORDS   = 512
`endif
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              mem_start,
  input  logic              mem_we,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] Mdatain,
  output logic [DATA_W-1:0] BusMuxIn_MDR
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic              we_q;
  logic              cnt_zero;
  logic              range_fault;

  mem_wait_counter u_wait_counter (
    .clk_i      (clock),
    .rst_ni     (clear),
    .load_i     (state_q == SETUP),
    .load_val_i (LoadVal),
    .dec_i      (state_q == ACCESS),
    .zero_o     (cnt_zero)
  );

`ifdef MEM_RANGE_CHECK_EN
  logic err_q;

  assign range_fault = (32'(mar_q) >= MEM_WORDS);

  // Fault is flagged while leaving SETUP, so err_q is high exactly in DONE.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == SETUP) && range_fault;
    end
  end

  assign mem_err = err_q;
`else
  assign range_fault = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mem_start) state_d = SETUP;
      SETUP:   state_d = range_fault ? DONE : ACCESS;
      ACCESS:  if (cnt_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (MARin)     mar_q <= BusMuxOut[ADDR_W-1:0];
        if (MDRin)     mdr_q <= BusMuxOut;
        if (mem_start) we_q  <= mem_we;
      end
      // Capture on the edge that ends ACCESS, while the read strobe is still high.
      if ((state_q == ACCESS) && cnt_zero && !we_q) begin
        mdr_q <= Mdatain;
      end
    end
  end

  assign mem_busy     = (state_q != IDLE);
  assign mem_done     = (state_q == DONE);
  assign ram_read     = (state_q == ACCESS) && !we_q;
  assign ram_write    = (state_q == ACCESS) && we_q;
  assign ram_address  = mar_q;
  assign ram_wdata    = mdr_q;
  assign BusMuxIn_MDR = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (WAIT_CYCLES 2, 1, 15), each with a RAM and a
// cycle-age model; directed accesses plus literal latency/data expectations.
module tb_mem_access_ctrl;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  logic [2:0]       marin, mdrin, mem_start, mem_we;
  logic [2:0][31:0] bus;
  logic [2:0]       busy, done, err, rd, wr;
  logic [2:0][8:0]  addr;
  logic [2:0][31:0] wdata, mdr_out, rdata;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int W  = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    localparam int MW = (g == 1) ? 256 : 512;

    mem_access_ctrl #(
      .ADDR_W      (9),
      .DATA_W      (32),
      .WAIT_CYCLES (W)
`ifdef MEM_RANGE_CHECK_EN
      ,
      .MEM_WORDS   (MW)
`endif
    ) u_dut (
      .clock        (clock),
      .clear        (clear),
      .MARin        (marin[g]),
      .MDRin        (mdrin[g]),
      .BusMuxOut    (bus[g]),
      .mem_start    (mem_start[g]),
      .mem_we       (mem_we[g]),
      .mem_busy     (busy[g]),
      .mem_done     (done[g]),
      .mem_err      (err[g]),
      .ram_read     (rd[g]),
      .ram_write    (wr[g]),
      .ram_address  (addr[g]),
      .ram_wdata    (wdata[g]),
      .Mdatain      (rdata[g]),
      .BusMuxIn_MDR (mdr_out[g])
    );

    logic [31:0] ram    [512];
    logic [31:0] shadow [512];

    initial begin
      for (int i = 0; i < 512; i++) begin
        ram[i]    = '0;
        shadow[i] = '0;
      end
    end

    always @(posedge clock) if (wr[g]) ram[addr[g]] <= wdata[g];
    assign rdata[g] = rd[g] ? ram[addr[g]] : '0;

    // Model: age counts cycles since the start was accepted (0 = idle).
    int          age;
    logic [8:0]  m_mar;
    logic [31:0] m_mdr;
    logic        m_we, m_err;

    always @(posedge clock or negedge clear) begin
      if (!clear) begin
        age <= 0; m_mar <= '0; m_mdr <= '0; m_we <= 1'b0; m_err <= 1'b0;
      end else if (age == 0) begin
        if (marin[g]) m_mar <= bus[g][8:0];
        if (mdrin[g]) m_mdr <= bus[g];
        if (mem_start[g]) begin
          age  <= 1;
          m_we <= mem_we[g];
        end
      end else if (age == W + 2) begin
        age   <= 0;
        m_err <= 1'b0;
      end else begin
        age <= age + 1;
`ifdef MEM_RANGE_CHECK_EN
        if (age == 1 && int'(m_mar) >= MW) begin
          age   <= W + 2;
          m_err <= 1'b1;
        end
`endif
        if (age == W + 1) begin
          if (m_we) shadow[m_mar] <= m_mdr;
          else      m_mdr <= shadow[m_mar];
        end
      end
    end

    always @(negedge clock) begin
      logic strobe;
      logic [77:0] act, exp;
      strobe = (age >= 2) && (age <= W + 1);
      exp = {age != 0, age == W + 2, m_err && (age == W + 2), strobe && !m_we, strobe && m_we,
             m_mar, m_mdr, m_mdr};
      act = {busy[g], done[g], err[g], rd[g], wr[g], addr[g], wdata[g], mdr_out[g]};
      chk($sformatf("cycle_w%0d", W), 128'(act), 128'(exp));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_mar(input int k, input logic [31:0] v);
    bus[k] = v; marin[k] = 1'b1; tick(); marin[k] = 1'b0;
  endtask

  task automatic do_mdr(input int k, input logic [31:0] v);
    bus[k] = v; mdrin[k] = 1'b1; tick(); mdrin[k] = 1'b0;
  endtask

  // Runs one access over a fixed window; lat = cycle of first mem_done, cycle 0 = start edge.
  task automatic access(input int k, input logic w, input bit inj,
                        output int lat, output int sw, output int bc, output int dc,
                        output int ec);
    int n;
    n = ((k == 0) ? 2 : (k == 1) ? 1 : 15) + 4;
    lat = 0; sw = 0; bc = 0; dc = 0; ec = 0;
    mem_we[k] = w; mem_start[k] = 1'b1;
    tick();
    mem_start[k] = 1'b0;
    for (int c = 1; c <= n; c++) begin
      if (inj && c == 2) begin
        bus[k] = 32'h1234_5678; marin[k] = 1'b1; mdrin[k] = 1'b1; mem_start[k] = 1'b1;
      end
      if (inj && c == 3) begin
        marin[k] = 1'b0; mdrin[k] = 1'b0; mem_start[k] = 1'b0;
      end
      if (done[k]) begin
        dc++;
        if (lat == 0) lat = c;
      end
      if (rd[k] || wr[k]) sw++;
      if (busy[k]) bc++;
      if (err[k]) ec++;
      tick();
    end
  endtask

  int lat, sw, bc, dc, ec;

  initial begin
    marin = '0; mdrin = '0; mem_start = '0; mem_we = '0; bus = '0;
    clear = 1'b0;
    tick(); tick();
    clear = 1'b1;
    tick();
    chk("reset_mdr", 128'(mdr_out[0]), 128'h0);
    chk("reset_busy", 128'(busy[0]), 128'h0);

    // Write 0xDEADBEEF to 0x055
    do_mar(0, 32'h0000_0055);
    do_mdr(0, 32'hDEAD_BEEF);
    access(0, 1'b1, 1'b0, lat, sw, bc, dc, ec);
    chk("wr_latency", 128'(lat), 128'd4);
    chk("wr_strobe_width", 128'(sw), 128'd2);
    chk("wr_ram_word", 128'(g_inst[0].ram[9'h055]), 128'hDEAD_BEEF);

    // Read it back after clobbering MDR
    do_mdr(0, 32'h0);
    access(0, 1'b0, 1'b0, lat, sw, bc, dc, ec);
    chk("rd_latency", 128'(lat), 128'd4);
    chk("rd_strobe_width", 128'(sw), 128'd2);
    chk("rd_busy_cycles", 128'(bc), 128'd4);
    chk("rd_data", 128'(mdr_out[0]), 128'hDEAD_BEEF);

    do_mar(0, 32'hABCD_FE55);
    chk("mar_upper_bits", 128'(addr[0]), 128'h055);

    // Mid-access MARin/MDRin/mem_start must be ignored
    do_mar(0, 32'h0000_00AA);
    do_mdr(0, 32'h0BAD_F00D);
    access(0, 1'b1, 1'b1, lat, sw, bc, dc, ec);
    chk("inj_single_done", 128'(dc), 128'd1);
    chk("inj_addr", 128'(addr[0]), 128'h0AA);
    chk("inj_wdata", 128'(wdata[0]), 128'h0BAD_F00D);
    chk("inj_ram_word", 128'(g_inst[0].ram[9'h0AA]), 128'h0BAD_F00D);

    // Reset during ACCESS of a read
    do_mar(0, 32'h0000_0055);
    mem_we[0] = 1'b0; mem_start[0] = 1'b1;
    tick();
    mem_start[0] = 1'b0;
    tick();
    chk("pre_abort_read", 128'(rd[0]), 128'h1);
    clear = 1'b0;
    #1;
    chk("abort_strobe", 128'(rd[0]), 128'h0);
    chk("abort_mdr", 128'(mdr_out[0]), 128'h0);
    chk("abort_busy", 128'(busy[0]), 128'h0);
    tick();
    clear = 1'b1;
    tick();
    do_mar(0, 32'h0000_0055);
    access(0, 1'b0, 1'b0, lat, sw, bc, dc, ec);
    chk("post_abort_latency", 128'(lat), 128'd4);
    chk("post_abort_data", 128'(mdr_out[0]), 128'hDEAD_BEEF);

    // WAIT_CYCLES = 1 and 15
    for (int k = 1; k < 3; k++) begin
      do_mar(k, 32'h0000_0033);
      do_mdr(k, 32'h5A5A_0000 + k);
      access(k, 1'b1, 1'b0, lat, sw, bc, dc, ec);
      do_mdr(k, 32'h0);
      access(k, 1'b0, 1'b0, lat, sw, bc, dc, ec);
      chk($sformatf("w_latency_%0d", k), 128'(lat), (k == 1) ? 128'd3 : 128'd17);
      chk($sformatf("w_strobe_%0d", k), 128'(sw), (k == 1) ? 128'd1 : 128'd15);
      chk($sformatf("w_data_%0d", k), 128'(mdr_out[k]), 128'(32'h5A5A_0000 + k));
    end

`ifdef MEM_RANGE_CHECK_EN
    do_mdr(1, 32'h1111_2222);
    do_mar(1, 32'h0000_0100);
    access(1, 1'b0, 1'b0, lat, sw, bc, dc, ec);
    chk("fault_latency", 128'(lat), 128'd2);
    chk("fault_strobe", 128'(sw), 128'd0);
    chk("fault_err", 128'(ec), 128'd1);
    chk("fault_mdr", 128'(mdr_out[1]), 128'h1111_2222);
    do_mar(1, 32'h0000_00FF);
    access(1, 1'b0, 1'b0, lat, sw, bc, dc, ec);
    chk("edge_latency", 128'(lat), 128'd3);
    chk("edge_err", 128'(ec), 128'd0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
